level_setpoint_ctrl: RTL and testbench

Operator setpoint and pump-control stage that sits directly downstream of the key debounce filters. It consumes their single-cycle `press` pulses (mode, up, down) and runs a small edit state machine, so the operator can adjust the high and low water-level thresholds. It compares the sensed level against those thresholds with hysteresis to drive the drain pump, and raises an over-level alarm.

---
 rtl/level_setpoint_ctrl.sv | 113 +++++++++++
 tb/tb_level_setpoint_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/level_setpoint_ctrl.sv
// Operator setpoint editor and drain-pump controller: mode/up/down pulses edit the
// high/low level thresholds; the sensed level drives a hysteretic pump and an alarm.
module level_setpoint_ctrl #(
  parameter int LEVEL_W     = 8,
  parameter int HIGH_INIT   = 200,
  parameter int LOW_INIT    = 50,
  parameter int STEP        = 5,
  parameter int MIN_GAP     = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_press,
  input  logic               up_press,
  input  logic               down_press,
  input  logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] high_thr,
  output logic [LEVEL_W-1:0] low_thr,
  output logic [1:0]         edit_state,
  output logic               pump_on,
  output logic               alarm
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SET_HIGH = 2'd1;
  localparam logic [1:0] ST_SET_LOW  = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [LEVEL_W:0] STEP_X = (LEVEL_W+1)'(STEP);
  localparam logic [LEVEL_W:0] GAP_X  = (LEVEL_W+1)'(MIN_GAP);
  localparam logic [LEVEL_W:0] MAX_X  = {1'b0, {LEVEL_W{1'b1}}};

  // Sums and differences use one extra bit so nothing wraps before clamping.
  function automatic logic [LEVEL_W-1:0] step_up(input logic [LEVEL_W-1:0] val,
                                                 input logic [LEVEL_W:0]   ceil);
    logic [LEVEL_W:0] sum;
    sum = {1'b0, val} + STEP_X;
    return (sum > ceil) ? ceil[LEVEL_W-1:0] : sum[LEVEL_W-1:0];
  endfunction

  function automatic logic [LEVEL_W-1:0] step_dn(input logic [LEVEL_W-1:0] val,
                                                 input logic [LEVEL_W:0]   floor);
    logic [LEVEL_W:0] diff;
    diff = {1'b0, val} - STEP_X;
    if (({1'b0, val} < STEP_X) || (diff < floor))
      return floor[LEVEL_W-1:0];
    return diff[LEVEL_W-1:0];
  endfunction

  logic [CNT_W-1:0] idle_cnt;
  logic [1:0]       mode_next;
  logic             inc_req;
  logic             dec_req;

  always_comb begin
    mode_next = ST_RUN;
    case (edit_state)
      ST_RUN:      mode_next = ST_SET_HIGH;
      ST_SET_HIGH: mode_next = ST_SET_LOW;
      default:     mode_next = ST_RUN;
    endcase
  end

  // Up and down together cancel; mode wins over both.
  assign inc_req = up_press & ~down_press & ~mode_press;
  assign dec_req = down_press & ~up_press & ~mode_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edit_state <= ST_RUN;
      high_thr   <= LEVEL_W'(HIGH_INIT);
      low_thr    <= LEVEL_W'(LOW_INIT);
      idle_cnt   <= '0;
      pump_on    <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      if (level >= high_thr)
        pump_on <= 1'b1;
      else if (level <= low_thr)
        pump_on <= 1'b0;
      alarm <= ({1'b0, level} > ({1'b0, high_thr} + GAP_X));

      if (mode_press) begin
        edit_state <= mode_next;
        idle_cnt   <= '0;
      end else if (edit_state != ST_RUN) begin
        if (up_press || down_press) begin
          idle_cnt <= '0;
        end else if (idle_cnt == CNT_LAST) begin
          edit_state <= ST_RUN;
          idle_cnt   <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end

        if (edit_state == ST_SET_HIGH) begin
          if (inc_req)
            high_thr <= step_up(high_thr, MAX_X);
          else if (dec_req)
            high_thr <= step_dn(high_thr, {1'b0, low_thr} + GAP_X);
        end else begin
          if (inc_req)
            low_thr <= step_up(low_thr, {1'b0, high_thr} - GAP_X);
          else if (dec_req)
            low_thr <= step_dn(low_thr, '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_level_setpoint_ctrl.sv
// Scoreboard bench for level_setpoint_ctrl: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_level_setpoint_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_press = 1'b0;
  logic       up_press = 1'b0;
  logic       down_press = 1'b0;
  logic [7:0] level = 8'd0;
  logic [7:0] high_thr;
  logic [7:0] low_thr;
  logic [1:0] edit_state;
  logic       pump_on;
  logic       alarm;

  level_setpoint_ctrl dut (
    .clk(clk), .reset(reset), .mode_press(mode_press), .up_press(up_press),
    .down_press(down_press), .level(level), .high_thr(high_thr), .low_thr(low_thr),
    .edit_state(edit_state), .pump_on(pump_on), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam int K_HIGH = 0, K_LOW = 1, K_STATE = 2, K_PUMP = 3, K_ALARM = 4;

  function automatic int actual(input int kind);
    case (kind)
      K_HIGH:  return int'(high_thr);
      K_LOW:   return int'(low_thr);
      K_STATE: return int'(edit_state);
      K_PUMP:  return int'(pump_on);
      default: return int'(alarm);
    endcase
  endfunction

  // Sorted insert keeps the queue ordered by target cycle.
  task automatic exp_at(input int dc, input int kind, input int val, input string name);
    exp_t e;
    int idx;
    e.cyc = cyc + dc; e.kind = kind; e.val = val; e.name = name;
    idx = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    q.insert(idx, e);
  endtask

  task automatic exp_reset(input int dc, input string tag);
    exp_at(dc, K_HIGH, 200, {tag, "_high"});
    exp_at(dc, K_LOW, 50, {tag, "_low"});
    exp_at(dc, K_STATE, 0, {tag, "_state"});
    exp_at(dc, K_PUMP, 0, {tag, "_pump"});
    exp_at(dc, K_ALARM, 0, {tag, "_alarm"});
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      int a;
      e = q.pop_front();
      checks++;
      a = actual(e.kind);
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s missed at cycle %0d (required %0d)", e.name, e.cyc, e.val);
      end else if (a != e.val) begin
        errors++;
        $display("FAIL %s cycle %0d got %0d expected %0d", e.name, cyc, a, e.val);
      end
    end
  end

  task automatic step(input logic m, input logic u, input logic d);
    @(negedge clk);
    mode_press = m;
    up_press   = u;
    down_press = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    mode_press = 1'b0; up_press = 1'b0; down_press = 1'b0; level = 8'd0;
    reset = 1'b1;
    exp_reset(1, tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int high_up_tbl[12] = '{205, 210, 215, 220, 225, 230, 235, 240, 245, 250, 255, 255};
  int low_dn_tbl[11]  = '{45, 40, 35, 30, 25, 20, 15, 10, 5, 0, 0};
  int c0;
  int p;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(10);
    exp_reset(1, "rst_idle");

    // High threshold saturates at 255, then clamps at low+gap.
    step(1'b1, 1'b0, 1'b0);
    exp_at(1, K_STATE, 1, "enter_set_high");
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0);
      exp_at(1, K_HIGH, high_up_tbl[i], "high_up");
      idle(2);
    end
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b1);
      exp_at(1, K_HIGH, (255 - 5 * (i + 1) < 60) ? 60 : 255 - 5 * (i + 1), "high_dn");
      idle(1);
    end
    exp_at(1, K_PUMP, 0, "pump_idle_edit");

    // Low threshold clamps at high-gap, then at zero.
    do_reset("rst2");
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    exp_at(1, K_STATE, 2, "enter_set_low");
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b1, 1'b0);
      exp_at(1, K_LOW, (50 + 5 * (i + 1) > 190) ? 190 : 50 + 5 * (i + 1), "low_up");
      idle(1);
    end
    do_reset("rst3");
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b0, 1'b1);
      exp_at(1, K_LOW, low_dn_tbl[i], "low_dn");
      idle(1);
    end

    // Level ramp with hysteresis at 200/50 and alarm above 210.
    do_reset("rst4");
    idle(1);
    p = 0;
    for (int i = 0; i < 511; i++) begin
      int lv;
      lv = (i <= 255) ? i : 510 - i;
      @(negedge clk);
      level = 8'(lv);
      if (lv >= 200) p = 1;
      else if (lv <= 50) p = 0;
      exp_at(1, K_PUMP, p, "ramp_pump");
      exp_at(1, K_ALARM, (lv > 210) ? 1 : 0, "ramp_alarm");
    end
    @(negedge clk);
    level = 8'd0;

    // Edit timeout from state entry.
    do_reset("rst5");
    step(1'b1, 1'b0, 1'b0);
    exp_at(1, K_STATE, 1, "to_enter");
    exp_at(1000, K_STATE, 1, "to_before");
    exp_at(1001, K_STATE, 0, "to_expire");
    idle(1002);

    // Timeout restarts from an up press on the last idle cycle.
    step(1'b1, 1'b0, 1'b0);
    c0 = cyc;
    idle(998);
    step(1'b0, 1'b1, 1'b0);
    exp_at(1, K_HIGH, 205, "to_up_high");
    exp_at(2, K_STATE, 1, "to_no_early");
    exp_at(1000, K_STATE, 1, "to_re_before");
    exp_at(1001, K_STATE, 0, "to_re_expire");
    exp_at(1001, K_HIGH, 205, "to_keep_high");
    idle(1002);

    // Simultaneous pulses and reset mid-edit.
    do_reset("rst6");
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    exp_at(1, K_HIGH, 200, "updn_high");
    exp_at(1, K_STATE, 1, "updn_state");
    step(1'b1, 1'b1, 1'b0);
    exp_at(1, K_STATE, 2, "modeup_state");
    exp_at(1, K_HIGH, 200, "modeup_high");
    step(1'b0, 1'b1, 1'b0);
    exp_at(1, K_LOW, 55, "edit_low");
    idle(2);
    do_reset("rst_mid");
    idle(3);
    exp_reset(1, "post_rst");
    idle(3);

    for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never checked (cycle %0d, required %0d)", e.name, e.cyc, e.val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
